// File: rtl/tlul_host_adapter_reg.sv
// tlul_host_adapter_reg
//   Register-style TL-UL initiator. A client hands over one request
//   (req/gnt), the adapter runs it on the A channel, waits for the D
//   response and reports a single-cycle completion (valid/rdata/err).
//   One transaction outstanding at a time; optional command integrity
//   generation, response integrity checking and a response timeout.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i / gnt_o          client request / accepted this cycle
//   we_i, addr_i, wdata_i, be_i   request attributes
//   valid_o, rdata_o, err_o       completion pulse and its result
//   busy_o                 transaction in flight or being drained
//   intg_err_o             sticky response-integrity error
//   tl_o / tl_i            TL-UL host request / device response

package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // 7-bit check code: bit i%7 accumulates the parity of every 7th input bit.
  function automatic logic [6:0] intg_code(input logic [63:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c[i % 7] = c[i % 7] ^ d[i];
    return c;
  endfunction
endpackage

module tlul_host_adapter_reg
  import tlul_pkg::*;
#(
  parameter int RegAw              = 32,
  parameter int RegDw              = 32,
  parameter int SourceId           = 0,
  parameter int EnableCmdIntgGen   = 0,
  parameter int EnableRspIntgCheck = 0,
  parameter int TimeoutCycles      = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic               we_i,
  input  logic [RegAw-1:0]   addr_i,
  input  logic [RegDw-1:0]   wdata_i,
  input  logic [RegDw/8-1:0] be_i,
  output logic               valid_o,
  output logic [RegDw-1:0]   rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               intg_err_o,
  output tl_h2d_t            tl_o,
  input  tl_d2h_t            tl_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  state_e             r_state;
  logic               r_we;
  logic [RegAw-1:0]   r_addr;
  logic [RegDw-1:0]   r_wdata;
  logic [RegDw/8-1:0] r_be;
  logic [CntW-1:0]    r_cnt;
  logic               r_valid;
  logic               r_err;
  logic [RegDw-1:0]   r_rdata;
  logic               r_intg_err;

  logic               w_gnt;
  logic               w_d_ready;
  logic [2:0]         w_aop;
  logic [RegAw-1:0]   w_addr_al;
  logic [TL_AW-1:0]   w_addr_tl;
  logic [TL_DBW-1:0]  w_mask;
  logic [2:0]         w_exp_dop;
  logic               w_rsp_intg_err;
  logic               w_rsp_err;
  logic               w_timeout;
  logic               w_unused;

  // Grant is held off during the completion cycle so consecutive grants
  // are spaced by the full request/response round trip.
  assign w_gnt     = !rst_i && (r_state == IDLE) && !r_valid && req_i;
  assign w_d_ready = (r_state == DATA) || (r_state == DRAIN);

  assign w_aop     = r_we ? ((&r_be) ? PutFullData : PutPartialData) : Get;
  assign w_addr_al = {r_addr[RegAw-1:2], 2'b00};
  assign w_addr_tl = TL_AW'(w_addr_al);
  assign w_mask    = r_we ? r_be : '1;
  assign w_exp_dop = r_we ? AccessAck : AccessAckData;

  assign w_rsp_intg_err = (EnableRspIntgCheck != 0) &&
    ((intg_code(64'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error})) != tl_i.d_user.rsp_intg) ||
     (intg_code(64'(tl_i.d_data)) != tl_i.d_user.data_intg));

  assign w_rsp_err = tl_i.d_error ||
                     (tl_i.d_source != TL_AIW'(SourceId)) ||
                     (tl_i.d_opcode != w_exp_dop) ||
                     w_rsp_intg_err;

  // Fires in the last permitted DATA cycle when no response shows up;
  // a response arriving in that same cycle wins.
  assign w_timeout = (TimeoutCycles > 0) && (r_state == DATA) && !tl_i.d_valid &&
                     (r_cnt == CntW'(TimeoutCycles - 1));

  assign w_unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, r_addr[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_intg_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (tl_i.a_ready) begin
            r_cnt   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (tl_i.d_valid) begin
            r_valid <= 1'b1;
            r_err   <= w_rsp_err;
            r_rdata <= (!w_rsp_err && !r_we) ? tl_i.d_data : '1;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '1;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // The late response is swallowed without a completion.
          if (tl_i.d_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_d_ready && tl_i.d_valid && w_rsp_intg_err) r_intg_err <= 1'b1;
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (r_state == ADDR);
    tl_o.a_opcode  = w_aop;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = TL_AIW'(SourceId);
    tl_o.a_address = w_addr_tl;
    tl_o.a_mask    = w_mask;
    tl_o.a_data    = r_wdata;
    tl_o.d_ready   = w_d_ready;
    if (EnableCmdIntgGen != 0) begin
      tl_o.a_user.cmd_intg  = intg_code(64'({w_aop, w_addr_tl, w_mask}));
      tl_o.a_user.data_intg = intg_code(64'(r_wdata));
    end
  end

  assign gnt_o      = w_gnt;
  assign valid_o    = r_valid;
  assign err_o      = r_err;
  assign rdata_o    = r_rdata;
  assign busy_o     = (r_state != IDLE);
  assign intg_err_o = r_intg_err;

endmodule

// File: tb/tb_tlul_host_adapter_reg.sv
// Randomized + directed bench for tlul_host_adapter_reg with a
// transaction-level reference model of the expected A-channel request
// and completion result.
module tb_tlul_host_adapter_reg;
  import tlul_pkg::*;

  localparam int          TO  = 8;
  localparam logic [7:0]  SRC = 8'h05;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt_o, valid_o, err_o, busy_o, intg_err_o;
  logic [31:0] rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     dev;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  tlul_host_adapter_reg #(
    .RegAw(32), .RegDw(32), .SourceId(int'(SRC)),
    .EnableCmdIntgGen(0), .EnableRspIntgCheck(0), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .valid_o(valid_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .intg_err_o(intg_err_o), .tl_o(tl_o), .tl_i(dev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: what the request should look like on the wire.
  function automatic logic [2:0] m_aop(input logic w, input logic [3:0] b);
    if (!w) return 3'd4;
    return (b == 4'hF) ? 3'd0 : 3'd1;
  endfunction

  // Reference model: completion result from the response fields.
  function automatic logic m_err(input logic w, input logic derr,
                                 input logic [7:0] dsrc, input logic [2:0] dop);
    logic [2:0] want;
    want = w ? 3'd0 : 3'd1;
    return derr || (dsrc != SRC) || (dop != want);
  endfunction

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input int aw, input int dw,
                        input logic derr, input logic [7:0] dsrc,
                        input logic [2:0] dop, input logic [31:0] dd);
    int   tg;
    bit   got;
    logic e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    #1;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (gnt_o) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("gnt_wait", 64'(got), 64'd1);
    if (!got) begin req = 1'b0; return; end
    tg = cyc;
    @(posedge clk); #1;
    req = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; be = $urandom;
    for (int i = 0; i <= aw; i++) begin
      @(negedge clk);
      chk("a_valid",   64'(tl_o.a_valid), 64'd1);
      chk("a_opcode",  64'(tl_o.a_opcode), 64'(m_aop(w, b)));
      chk("a_address", 64'(tl_o.a_address), 64'(a & 32'hFFFF_FFFC));
      chk("a_mask",    64'(tl_o.a_mask), w ? 64'(b) : 64'hF);
      if (w) chk("a_data", 64'(tl_o.a_data), 64'(wd));
      chk("a_source",  64'(tl_o.a_source), 64'(SRC));
      chk("a_size",    64'(tl_o.a_size), 64'd2);
      chk("busy_addr", 64'(busy_o), 64'd1);
      chk("d_ready_addr", 64'(tl_o.d_ready), 64'd0);
      req = 1'b1; #1;
      chk("gnt_busy", 64'(gnt_o), 64'd0);
      req = 1'b0;
      if (i == aw) dev.a_ready = 1'b1;
    end
    @(posedge clk); #1;
    dev.a_ready = 1'b0;
    for (int j = 0; j <= dw; j++) begin
      @(negedge clk);
      chk("d_ready",    64'(tl_o.d_ready), 64'd1);
      chk("a_valid_dn", 64'(tl_o.a_valid), 64'd0);
      chk("early_valid", 64'(valid_o), 64'd0);
      if (j == dw) begin
        dev.d_valid  = 1'b1;
        dev.d_error  = derr;
        dev.d_source = dsrc;
        dev.d_opcode = dop;
        dev.d_data   = dd;
      end
    end
    @(posedge clk); #1;
    dev.d_valid = 1'b0; dev.d_error = 1'b0;
    @(negedge clk);
    e_err = m_err(w, derr, dsrc, dop);
    e_rd  = (e_err || w) ? 32'hFFFF_FFFF : dd;
    chk("valid",     64'(valid_o), 64'd1);
    chk("err",       64'(err_o), 64'(e_err));
    chk("rdata",     64'(rdata_o), 64'(e_rd));
    chk("latency",   64'(cyc - tg), 64'(3 + aw + dw));
    chk("busy_done", 64'(busy_o), 64'd0);
    req = 1'b1; #1;
    chk("gnt_gap", 64'(gnt_o), 64'd0);
    req = 1'b0;
    @(negedge clk);
    chk("valid_pulse", 64'(valid_o), 64'd0);
  endtask

  task automatic do_timeout();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40; be = 4'hF; #1;
    chk("to_gnt", 64'(gnt_o), 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("to_a_valid", 64'(tl_o.a_valid), 64'd1);
    dev.a_ready = 1'b1;
    @(posedge clk); #1;
    dev.a_ready = 1'b0;
    // DATA cycles are numbered from 0; completion is expected at DATA cycle TO.
    for (int n = 0; n <= TO; n++) begin
      @(negedge clk);
      if (n < TO) begin
        chk("to_wait_valid", 64'(valid_o), 64'd0);
      end else begin
        chk("to_valid", 64'(valid_o), 64'd1);
        chk("to_err",   64'(err_o), 64'd1);
        chk("to_rdata", 64'(rdata_o), 64'hFFFF_FFFF);
      end
    end
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      chk("drain_busy",    64'(busy_o), 64'd1);
      chk("drain_d_ready", 64'(tl_o.d_ready), 64'd1);
      chk("drain_valid",   64'(valid_o), 64'd0);
      req = 1'b1; #1;
      chk("drain_gnt", 64'(gnt_o), 64'd0);
      req = 1'b0;
      if (m == 4) begin
        dev.d_valid = 1'b1; dev.d_source = SRC; dev.d_opcode = 3'd1;
        dev.d_data = 32'hCAFE_F00D;
      end
    end
    @(posedge clk); #1;
    dev.d_valid = 1'b0;
    @(negedge clk);
    chk("drain_novalid", 64'(valid_o), 64'd0);
    chk("drain_idle",    64'(busy_o), 64'd0);
    req = 1'b1; #1;
    chk("gnt_after_drain", 64'(gnt_o), 64'd1);
    req = 1'b0;
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h80; be = 4'hF; #1;
    chk("rst_gnt", 64'(gnt_o), 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    dev.a_ready = 1'b1;
    @(posedge clk); #1;
    dev.a_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_data", 64'(tl_o.d_ready), 64'd1);
    rst = 1'b1; #1;
    chk("rst_a_valid", 64'(tl_o.a_valid), 64'd0);
    chk("rst_d_ready", 64'(tl_o.d_ready), 64'd0);
    chk("rst_busy",    64'(busy_o), 64'd0);
    chk("rst_valid",   64'(valid_o), 64'd0);
    chk("rst_rdata",   64'(rdata_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        w;
    logic [3:0]  b;
    logic        derr;
    logic [7:0]  dsrc;
    logic [2:0]  dop;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    dev = '0;
    repeat (2) @(negedge clk);
    req = 1'b1; #1;
    chk("reset_gnt",      64'(gnt_o), 64'd0);
    chk("reset_a_valid",  64'(tl_o.a_valid), 64'd0);
    chk("reset_d_ready",  64'(tl_o.d_ready), 64'd0);
    chk("reset_valid",    64'(valid_o), 64'd0);
    chk("reset_err",      64'(err_o), 64'd0);
    chk("reset_busy",     64'(busy_o), 64'd0);
    chk("reset_intg_err", 64'(intg_err_o), 64'd0);
    chk("reset_rdata",    64'(rdata_o), 64'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Stray response while idle must not be accepted.
    @(negedge clk);
    dev.d_valid = 1'b1; #1;
    chk("stray_d_ready", 64'(tl_o.d_ready), 64'd0);
    @(negedge clk);
    chk("stray_valid", 64'(valid_o), 64'd0);
    dev.d_valid = 1'b0;

    do_txn(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, SRC, 3'd0, 32'h0);
    do_txn(1'b0, 32'h17, 32'h0, 4'hF, 0, 3, 1'b0, SRC, 3'd1, 32'h1234_5678);
    do_txn(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 5, 0, 1'b0, SRC, 3'd0, 32'h0);
    do_txn(1'b0, 32'h24, 32'h0, 4'hF, 0, 1, 1'b1, SRC, 3'd1, 32'h5555_AAAA);
    do_txn(1'b0, 32'h28, 32'h0, 4'hF, 0, 0, 1'b0, SRC + 8'd1, 3'd1, 32'h7777_0000);
    do_txn(1'b1, 32'h2C, 32'h1111_2222, 4'hF, 1, 0, 1'b0, SRC, 3'd1, 32'h9999_9999);
    // Response arriving in the very cycle the timeout would fire.
    do_txn(1'b0, 32'h30, 32'h0, 4'hF, 0, TO - 1, 1'b0, SRC, 3'd1, 32'hA5A5_5A5A);

    do_timeout();
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 1'b0, SRC, 3'd1, 32'h0F0F_0F0F);

    do_reset_mid();
    do_txn(1'b0, 32'h84, 32'h0, 4'hF, 0, 2, 1'b0, SRC, 3'd1, 32'h8484_8484);

    for (int t = 0; t < 40; t++) begin
      w    = $urandom_range(0, 1);
      b    = $urandom_range(0, 15);
      derr = ($urandom_range(0, 5) == 0);
      dsrc = ($urandom_range(0, 5) == 0) ? (SRC ^ 8'h01) : SRC;
      dop  = ($urandom_range(0, 3) == 0) ? (w ? 3'd1 : 3'd0) : (w ? 3'd0 : 3'd1);
      do_txn(w, $urandom, $urandom, b, $urandom_range(0, 3), $urandom_range(0, TO - 1),
             derr, dsrc, dop, $urandom);
    end

    chk("intg_err_final", 64'(intg_err_o), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlul_host_adapter_reg.md
Name: tlul_host_adapter_reg

Overview:
- Register-style initiator that issues single TL-UL transactions onto a device port and returns the response.
- Counterpart of the device-side register adapter.
- Used by bench agents and internal controllers (e.g. a DMA or config sequencer) to reach CSR blocks over TL-UL.
- One transaction outstanding at a time. Optional command-integrity generation, response-integrity check and response timeout.

Parameters:
- RegAw, 32, width of addr_i. Zero-extended or truncated to the TL address width.
- RegDw, 32, data width. Must equal top_pkg::TL_DW.
- SourceId, 0, value driven on a_source. Every response's d_source is checked against it.
- EnableCmdIntgGen, 0, 1 = fill a_user command/data integrity through tlul_cmd_intg_gen.
- EnableRspIntgCheck, 0, 1 = check response integrity through tlul_rsp_intg_chk.
- TimeoutCycles, 0, maximum cycles to wait for d_valid. 0 disables the timeout.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset.
- req_i, in, 1, request valid from the client.
- gnt_o, out, 1, request accepted this cycle.
- we_i, in, 1, 1 = write, 0 = read.
- addr_i, in, RegAw, byte address.
- wdata_i, in, RegDw, write data.
- be_i, in, RegDw/8, byte enables.
- valid_o, out, 1, one-cycle completion pulse.
- rdata_o, out, RegDw, read data, valid while valid_o is high.
- err_o, out, 1, completion had an error, valid while valid_o is high.
- busy_o, out, 1, a transaction is in flight or being drained.
- intg_err_o, out, 1, sticky response-integrity error.
- tl_o, out, tl_h2d_t, TL-UL host request.
- tl_i, in, tl_d2h_t, TL-UL device response.

Interface decision: one clock; reset is asynchronous and active-high. Ports are named clk_i and rst_i.

Behaviour:
- Reset (rst_i=1, any cycle, including mid-transaction) returns the FSM to IDLE. While in reset and immediately after it:
  - tl_o.a_valid=0, tl_o.d_ready=0;
  - gnt_o=0, valid_o=0, err_o=0, busy_o=0, intg_err_o=0;
  - rdata_o=0.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - gnt_o = req_i (combinational).
  - On req_i=1, latch we/addr/wdata/be into registers and go to ADDR.
  - busy_o=0.
- ADDR:
  - a_valid=1, driven from the registers, all A-channel fields held stable until a_ready.
  - a_opcode: PutFullData if we and be all ones; PutPartialData if we and be not all ones; Get if not we.
  - a_mask = be for writes, all ones for reads.
  - a_size=2. a_address = {addr[RegAw-1:2],2'b00}; low address bits are dropped.
  - a_source=SourceId, a_param=0.
  - On a_valid & a_ready, go to DATA.
  - No timeout counting in ADDR; a_valid is never withdrawn.
- DATA:
  - d_ready=1.
  - On d_valid, latch the response and go to IDLE. valid_o pulses the next cycle, so there is one cycle from d-handshake to completion.
  - Error term, OR of:
    - d_error;
    - d_source != SourceId;
    - opcode mismatch (read expects AccessAckData, write expects AccessAck);
    - response integrity error, when enabled.
  - rdata_o = d_data for an error-free read. It is all ones for any error and for writes.
- Timeout (TimeoutCycles > 0):
  - Counter clears on entry to DATA and increments each DATA cycle without d_valid.
  - When the counter reaches TimeoutCycles, complete with valid_o=1, err_o=1, rdata_o all ones, and go to DRAIN.
- DRAIN:
  - d_ready=1, busy_o=1, gnt_o=0.
  - The first accepted response is discarded, then return to IDLE. It produces no valid_o.
- Outside DATA and DRAIN, d_ready=0. A stray d_valid is not consumed.
- Minimum latency: gnt_o at cycle 0, a-handshake at cycle 1, d-handshake at cycle 2 with a zero-wait device, valid_o at cycle 3. Back-to-back grants are at least 4 cycles apart.
- busy_o=1 in ADDR, DATA and DRAIN.
- intg_err_o sets on any integrity error and clears only on reset.
- The d_valid that triggers the timeout is processed as a normal completion. The timeout applies only when d_valid is absent in that cycle.

Test Plan:
- Write: addr=0x14, wdata=0xDEADBEEF, be=0xF, zero-wait device → a_opcode=PutFullData, a_address=0x14, a_mask=0xF; valid_o at cycle 3 with err_o=0, rdata_o=0xFFFFFFFF.
- Read: addr=0x17, device returns AccessAckData with d_data=0x12345678 after 3 wait cycles → a_address=0x14, a_opcode=Get, a_mask=0xF; rdata_o=0x12345678, err_o=0.
- Partial write be=0x3 with a_ready held low for 5 cycles → PutPartialData; A-channel fields stable for all 5 cycles; gnt_o=0 while busy_o=1.
- Response errors: read returns d_error=1, then a read returns d_source=SourceId+1, then a write returns AccessAckData → each completes with err_o=1 and rdata_o=0xFFFFFFFF.
- Timeout: TimeoutCycles=8, device never responds → valid_o=1, err_o=1 at DATA cycle 8. A late response 4 cycles later is consumed with no valid_o, then gnt_o is available again.
- Assert rst_i while in DATA → a_valid=0, d_ready=0, busy_o=0 immediately; the next request after reset completes normally.
